// File: rtl/rv32i_mc_core_if.sv
// rv32i_mc_core_if: instruction/data SRAM bus between the core (master) and the memories (slave).
interface rv32i_mc_core_if;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic [31:0] instr_out;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    modport master (
        output instr_read, instr_addr, data_read, data_write, data_addr, data_in,
        input  instr_out, data_out
    );
    modport slave (
        input  instr_read, instr_addr, data_read, data_write, data_addr, data_in,
        output instr_out, data_out
    );
endinterface

// File: rtl/rv32i_mc_core.sv
// rv32i_mc_core: multi-cycle RV32I core (FETCH/EXEC/LOAD_WB) over one-cycle-latency SRAMs.
module rv32i_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    rv32i_mc_core_if.master bus
);
    typedef enum logic [1:0] {FETCH, EXEC, LOAD_WB} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] ir, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu, ld_addr, st_addr, maddr, ld_word, ld_val, rf_wd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, sh;
    logic [1:0]  off;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic        lt, ltu, take, rf_we, mem_act, st_en;
    assign ir     = bus.instr_out;
    assign opc    = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];
    assign rs1_v  = rf_q[ir[19:15]];
    assign rs2_v  = rf_q[ir[24:20]];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    // Anything not decoded as one of these falls through as a NOP.
    assign is_lui   = opc == 7'h37;
    assign is_auipc = opc == 7'h17;
    assign is_jal   = opc == 7'h6F;
    assign is_jalr  = opc == 7'h67 && f3 == 3'b000;
    assign is_br    = opc == 7'h63 && f3[2:1] != 2'b01;
    assign is_ld    = opc == 7'h03 && f3 != 3'b011 && f3[2:1] != 2'b11;
    assign is_st    = opc == 7'h23 && f3 < 3'b011;
    assign is_op    = opc == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
    assign is_opi   = opc == 7'h13 && (f3 == 3'b001 ? f7 == 7'h00 :
                                       f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
    assign op_b = (opc == 7'h33 || opc == 7'h63) ? rs2_v : imm_i;
    assign sh   = op_b[4:0];
    assign lt   = $signed(rs1_v) < $signed(op_b);
    assign ltu  = rs1_v < op_b;
    assign take = (f3[2] ? (f3[1] ? ltu : lt) : rs1_v == op_b) ^ f3[0];
    always_comb begin
        unique case (f3)
            3'b000:  alu = (opc == 7'h33 && ir[30]) ? rs1_v - op_b : rs1_v + op_b;
            3'b001:  alu = rs1_v << sh;
            3'b010:  alu = {31'b0, lt};
            3'b011:  alu = {31'b0, ltu};
            3'b100:  alu = rs1_v ^ op_b;
            3'b101:  alu = ir[30] ? 32'($signed(rs1_v) >>> sh) : rs1_v >> sh;
            3'b110:  alu = rs1_v | op_b;
            default: alu = rs1_v & op_b;
        endcase
    end
    assign ld_addr = rs1_v + imm_i;
    assign st_addr = rs1_v + imm_s;
    assign maddr   = is_st ? st_addr : ld_addr;
    assign off     = maddr[1:0];
    assign ld_word = bus.data_out >> (f3[1] ? 5'd0 : f3[0] ? {off[1], 4'b0} : {off, 3'b0});
    assign ld_val  = f3 == 3'b000 ? {{24{ld_word[7]}}, ld_word[7:0]} :
                     f3 == 3'b001 ? {{16{ld_word[15]}}, ld_word[15:0]} :
                     f3 == 3'b100 ? {24'b0, ld_word[7:0]} :
                     f3 == 3'b101 ? {16'b0, ld_word[15:0]} : ld_word;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rf_we   = 1'b0;
        rf_wd   = alu;
        if (state_q == FETCH) begin
            state_d = EXEC;
        end else if (state_q == LOAD_WB) begin
            state_d = FETCH;
            pc_d    = pc_q + 32'd4;
            rf_we   = 1'b1;
            rf_wd   = ld_val;
        end else begin
            state_d = is_ld ? LOAD_WB : FETCH;
            pc_d    = is_ld ? pc_q :
                      is_jal ? pc_q + imm_j :
                      is_jalr ? {ld_addr[31:1], 1'b0} :
                      (is_br && take) ? pc_q + imm_b : pc_q + 32'd4;
            rf_we   = is_lui | is_auipc | is_jal | is_jalr | is_op | is_opi;
            rf_wd   = is_lui ? imm_u :
                      is_auipc ? pc_q + imm_u :
                      (is_jal | is_jalr) ? pc_q + 32'd4 : alu;
        end
    end
    // Outputs are gated by rst so they drop the moment reset is asserted.
    assign mem_act        = !rst && ((state_q == EXEC && (is_ld || is_st)) || state_q == LOAD_WB);
    assign st_en          = !rst && state_q == EXEC && is_st;
    assign bus.instr_read = !rst && state_q == FETCH;
    assign bus.instr_addr = rst ? 32'b0 : pc_q;
    assign bus.data_read  = !rst && state_q == EXEC && is_ld;
    assign bus.data_addr  = mem_act ? maddr : 32'b0;
    assign bus.data_write = !st_en ? 4'b0 : f3[1] ? 4'b1111 :
                            f3[0] ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
    assign bus.data_in    = !st_en ? 32'b0 : f3[1] ? rs2_v :
                            f3[0] ? {2{rs2_v[15:0]}} : {4{rs2_v[7:0]}};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_rv32i_mc_core.sv
// tb_rv32i_mc_core: trace-driven bench; models both SRAMs and checks bus activity per instruction.
module tb_rv32i_mc_core;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          kind;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
    } vec_t;
    localparam int KN = 0, KS = 1, KL = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    vec_t v[$];
    int n_chk = 0;
    int n_fail = 0;
    rv32i_mc_core_if bus();
    rv32i_mc_core #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.instr_read) bus.instr_out <= imem[bus.instr_addr[9:2]];
        if (bus.data_read) bus.data_out <= dmem[bus.data_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (bus.data_write[b]) dmem[bus.data_addr[9:2]][8*b +: 8] <= bus.data_in[8*b +: 8];
    end
    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    task automatic add(input logic [31:0] pc, instr, input int kind, input logic [3:0] we,
                       input logic [31:0] addr, din);
        v.push_back('{pc, instr, kind, we, addr, din});
    endtask
    task automatic addn(input logic [31:0] pc, instr);
        add(pc, instr, KN, 4'b0, 32'b0, 32'b0);
    endtask
    task automatic chk(input string nm, input logic [31:0] pc, act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @pc=%h: got %h, expected %h", nm, pc, act, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    initial begin
        addn(32'h00, e_i(12'hFFB, 0, 0, 1, 7'h13));
        addn(32'h04, e_i(12'h003, 0, 0, 2, 7'h13));
        addn(32'h08, e_r(7'h20, 2, 1, 3'b000, 3));
        addn(32'h0C, e_r(7'h00, 2, 1, 3'b010, 4));
        addn(32'h10, e_r(7'h00, 2, 1, 3'b011, 7));
        addn(32'h14, e_r(7'h20, 2, 1, 3'b101, 6));
        addn(32'h18, e_i(12'h007, 0, 0, 0, 7'h13));
        add (32'h1C, e_s(12'h200, 3, 0, 3'b010), KS, 4'b1111, 32'h200, 32'hFFFF_FFF8);
        addn(32'h20, e_j(21'd16, 1));
        addn(32'h30, e_i(12'h040, 0, 0, 5, 7'h13));
        addn(32'h34, e_i(12'h001, 5, 0, 5, 7'h67));
        add (32'h40, e_s(12'h200, 5, 0, 3'b010), KS, 4'b1111, 32'h200, 32'h0000_0038);
        add (32'h44, e_s(12'h204, 1, 0, 3'b010), KS, 4'b1111, 32'h204, 32'h0000_0024);
        add (32'h48, e_s(12'h208, 4, 0, 3'b010), KS, 4'b1111, 32'h208, 32'h0000_0001);
        add (32'h4C, e_s(12'h20C, 6, 0, 3'b010), KS, 4'b1111, 32'h20C, 32'hFFFF_FFFF);
        add (32'h50, e_s(12'h210, 0, 0, 3'b010), KS, 4'b1111, 32'h210, 32'h0000_0000);
        add (32'h54, e_s(12'h214, 7, 0, 3'b010), KS, 4'b1111, 32'h214, 32'h0000_0000);
        addn(32'h58, e_u(20'h80818, 8, 7'h37));
        addn(32'h5C, e_i(12'h2F3, 8, 0, 8, 7'h13));
        addn(32'h60, e_i(12'h100, 0, 0, 9, 7'h13));
        add (32'h64, e_s(12'h000, 8, 9, 3'b010), KS, 4'b1111, 32'h100, 32'h8081_82F3);
        add (32'h68, e_i(12'h003, 9, 3'b000, 10, 7'h03), KL, 4'b0, 32'h103, 32'h0);
        add (32'h6C, e_i(12'h003, 9, 3'b100, 11, 7'h03), KL, 4'b0, 32'h103, 32'h0);
        add (32'h70, e_i(12'h002, 9, 3'b001, 12, 7'h03), KL, 4'b0, 32'h102, 32'h0);
        addn(32'h74, e_i(12'h055, 0, 0, 13, 7'h13));
        add (32'h78, e_s(12'h001, 13, 9, 3'b000), KS, 4'b0010, 32'h101, 32'h5555_5555);
        add (32'h7C, e_i(12'h000, 9, 3'b010, 14, 7'h03), KL, 4'b0, 32'h100, 32'h0);
        add (32'h80, e_s(12'h200, 10, 0, 3'b010), KS, 4'b1111, 32'h200, 32'hFFFF_FF80);
        add (32'h84, e_s(12'h204, 11, 0, 3'b010), KS, 4'b1111, 32'h204, 32'h0000_0080);
        add (32'h88, e_s(12'h208, 12, 0, 3'b010), KS, 4'b1111, 32'h208, 32'hFFFF_8081);
        add (32'h8C, e_s(12'h20C, 14, 0, 3'b010), KS, 4'b1111, 32'h20C, 32'h8081_55F3);
        add (32'h90, e_s(12'h002, 13, 9, 3'b001), KS, 4'b1100, 32'h102, 32'h0055_0055);
        addn(32'h94, e_i(12'hFFF, 0, 0, 15, 7'h13));
        addn(32'h98, e_i(12'h001, 0, 0, 16, 7'h13));
        addn(32'h9C, e_b(13'd8, 16, 15, 3'b100));
        addn(32'hA4, e_b(13'd8, 16, 15, 3'b110));
        addn(32'hA8, e_i(12'h002, 0, 0, 17, 7'h13));
        addn(32'hAC, e_i(12'hFFF, 17, 0, 17, 7'h13));
        addn(32'hB0, e_b(13'h1FFC, 16, 17, 3'b000));
        addn(32'hAC, e_i(12'hFFF, 17, 0, 17, 7'h13));
        addn(32'hB0, e_b(13'h1FFC, 16, 17, 3'b000));
        addn(32'hB4, 32'h0000_0073);
        addn(32'hB8, e_u(20'h00001, 18, 7'h17));
        add (32'hBC, e_s(12'h200, 18, 0, 3'b010), KS, 4'b1111, 32'h200, 32'h0000_10B8);
        add (32'hC0, e_s(12'h204, 17, 0, 3'b010), KS, 4'b1111, 32'h204, 32'h0000_0000);
        foreach (v[k]) imem[v[k].pc[9:2]] = v[k].instr;
        imem[8'h31] = e_s(12'h000, 15, 9, 3'b010);
        repeat (2) step();
        chk("rst_ctl", 32'h0, {27'b0, bus.instr_read, bus.data_read, bus.data_write}, 32'h0);
        chk("rst_iaddr", 32'h0, bus.instr_addr, 32'h0);
        rst = 1'b0;
        #1;
        foreach (v[k]) begin
            chk("fetch_rd", v[k].pc, {31'b0, bus.instr_read}, 32'h1);
            chk("fetch_pc", v[k].pc, bus.instr_addr, v[k].pc);
            step();
            chk("exec_ctl", v[k].pc, {27'b0, bus.data_read, bus.data_write},
                v[k].kind == KL ? 32'h10 : {28'b0, v[k].we});
            if (v[k].kind != KN) chk("exec_addr", v[k].pc, bus.data_addr, v[k].addr);
            if (v[k].kind == KS) chk("store_data", v[k].pc, bus.data_in, v[k].din);
            if (v[k].kind == KL) begin
                step();
                chk("ldwb_ctl", v[k].pc, {26'b0, bus.instr_read, bus.data_read, bus.data_write}, 32'h0);
                chk("ldwb_addr", v[k].pc, bus.data_addr, v[k].addr);
            end
            step();
        end
        chk("fetch_pc", 32'hC4, bus.instr_addr, 32'hC4);
        step();
        chk("abort_we", 32'hC4, {28'b0, bus.data_write}, 32'hF);
        rst = 1'b1;
        #1;
        chk("midrst_ctl", 32'hC4, {26'b0, bus.instr_read, bus.data_read, bus.data_write}, 32'h0);
        chk("midrst_iaddr", 32'hC4, bus.instr_addr, 32'h0);
        chk("midrst_daddr", 32'hC4, bus.data_addr, 32'h0);
        chk("midrst_din", 32'hC4, bus.data_in, 32'h0);
        imem[0] = e_s(12'h200, 1, 0, 3'b010);
        imem[1] = e_s(12'h204, 31, 0, 3'b010);
        repeat (2) step();
        chk("abort_mem", 32'hC4, dmem[8'h40], 32'h0055_55F3);
        rst = 1'b0;
        #1;
        chk("post_rst_rd", 32'h0, {31'b0, bus.instr_read}, 32'h1);
        chk("post_rst_pc", 32'h0, bus.instr_addr, 32'h0);
        step();
        chk("x1_clear", 32'h0, bus.data_in, 32'h0);
        chk("x1_we", 32'h0, {28'b0, bus.data_write}, 32'hF);
        step();
        chk("fetch_pc", 32'h4, bus.instr_addr, 32'h4);
        step();
        chk("x31_clear", 32'h4, bus.data_in, 32'h0);
        chk("x31_addr", 32'h4, bus.data_addr, 32'h204);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_mc_core.md
Name: rv32i_mc_core

Overview:
- RV32I integer CPU core driving two external word-addressed synchronous SRAMs: instruction memory and data memory.
- The memories use byte address bits [15:2] (16K words each). Each memory registers read data on the rising clk edge when its read strobe is high, and performs byte-enabled writes on the same edge.
- The core sequences each instruction through a small FSM to absorb the one-cycle memory read latency.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_read  out  1  instruction-memory read strobe.
- instr_addr  out  32  instruction byte address (current PC).
- instr_out  in  32  instruction word; valid the cycle after instr_read.
- data_read  out  1  data-memory read strobe.
- data_write  out  4  data-memory byte write enables; bit i writes byte lane i (bits [8i+7:8i]).
- data_addr  out  32  data byte address.
- data_in  out  32  store data, already shifted to the target byte lanes.
- data_out  in  32  load word; valid the cycle after data_read.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC; x1..x31=0; state=FETCH.
  - All outputs forced to 0 while rst is high.
  - Reset mid-instruction aborts it; no register or memory write completes.
- x0 reads 0 always; writes to x0 are discarded.
- FSM states: FETCH, EXEC, LOAD_WB.
- FETCH:
  - instr_read=1, instr_addr=PC; all data outputs 0.
  - Next state: EXEC.
- EXEC (instr_out valid): decode, read rs1/rs2, compute in ALU.
  - Non-memory instruction: write rd, update PC at end of cycle; next FETCH (2 cycles/instr).
  - Store:
    - data_addr=rs1+imm_s; data_write/data_in per size rules below.
    - Memory writes at the end of the cycle; PC+=4; next FETCH (2 cycles).
  - Load: data_read=1, data_addr=rs1+imm_i; next LOAD_WB.
- LOAD_WB (data_out valid):
  - Select and extend the loaded value, write rd, PC+=4; next FETCH (3 cycles/load).
  - data_read=0 in this state; data_addr holds its EXEC value.
- Outputs are combinational from state, instr_out and the register file. data_write is nonzero only in EXEC for stores.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR
  - BEQ, BNE, BLT, BGE, BLTU, BGEU
  - LB, LH, LW, LBU, LHU, SB, SH, SW
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA
- All other encodings (FENCE, ECALL, EBREAK, CSR, illegal) execute as NOP: PC+=4, no writes.
- Arithmetic:
  - 32-bit wrap-around; no overflow detection.
  - Shift amount = low 5 bits of rs2 or shamt.
  - SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
  - SRA/SRAI are arithmetic shifts.
- Immediates: I/S/B/U/J formats per the RV32I spec, sign-extended; B and J offsets have bit0=0.
- Control flow:
  - Branch taken: PC=PC+imm_b; not taken: PC+4.
  - JAL: rd=PC+4, PC=PC+imm_j.
  - JALR: rd=PC+4, PC=(rs1+imm_i)&~1, using the rs1 value read before the rd write (rd==rs1 safe).
  - No misalignment traps; instruction memory ignores PC[1:0].
- Store lanes, with off = data_addr[1:0]:
  - SB: data_write=4'b0001<<off; data_in=rs2[7:0] replicated to all 4 lanes.
  - SH: data_write=4'b0011<<{off[1],1'b0}; data_in={rs2[15:0],rs2[15:0]}; addr[0] ignored.
  - SW: data_write=4'b1111; data_in=rs2; addr[1:0] ignored.
- Load extraction:
  - LB/LBU: byte at lane off, sign- or zero-extended.
  - LH/LHU: halfword at lane off[1], sign- or zero-extended.
  - LW: the full word.
- No exceptions, interrupts or stalls; the memories always respond in exactly one cycle.

Test Plan:
- Reset: assert rst mid-EXEC -> all outputs 0 immediately; after release, first FETCH has instr_addr=0, instr_read=1; x1..x31 read 0.
- ALU: ADDI x1,x0,-5; ADDI x2,x0,3; then SUB, SLT, SLTU, SRA x1,x1,x2 -> x3=-8, SLT=1, SLTU=0, SRA=0xFFFFFFFF. Each instruction takes 2 cycles. ADDI x0,x0,7 leaves x0=0.
- Memory: SW 0x8081_82F3 at 0x100 -> data_write=1111. LB at 0x103 -> 0xFFFFFF80; LBU -> 0x80; LH at 0x102 -> 0xFFFF8081. SB 0x55 at 0x101 -> data_write=0010, data_in=0x55555555, word becomes 0x8081_55F3.
- Branches: BLT -1,1 taken to PC+8; BLTU -1,1 not taken, PC+4; BEQ with offset -4 loops back correctly.
- Jumps: JAL x1,+16 at PC 0x20 -> x1=0x24, PC=0x30. JALR x5,x5,1 with x5=0x40 -> PC=0x40, x5=old PC+4.
- Load timing: LW -> data_read=1 only in EXEC; rd written at end of LOAD_WB; next instr_addr=PC+4 after 3 cycles. Unsupported ECALL -> PC+4, no state change.
